// File: rtl/lsu_pkg.sv
// Shared types and constants for the psram load/store bridge.
package lsu_pkg;

    localparam int LSU_TIMEOUT_DEFAULT = 1024;
    localparam int PS_ADDR_W           = 22;

    typedef enum logic [1:0] {
        LSU_SIZE_BYTE = 2'd0,
        LSU_SIZE_HALF = 2'd1,
        LSU_SIZE_WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_ERR_NONE       = 2'd0,
        LSU_ERR_MISALIGNED = 2'd1,
        LSU_ERR_TIMEOUT    = 2'd2
    } lsu_err_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_LO = 3'd1,
        ST_WAIT_LO  = 3'd2,
        ST_ISSUE_HI = 3'd3,
        ST_WAIT_HI  = 3'd4,
        ST_DONE     = 3'd5
    } lsu_state_e;

    // Size code 3 is undefined on the core side; it is handled like a word.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = addr_lo[0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data lane select and sign/zero extension to 32 bits.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic        lane_hi,
    input  logic [15:0] data_lo,
    input  logic [15:0] data_hi,
    output logic [31:0] data
);

    logic [7:0] byte_sel;

    assign byte_sel = lane_hi ? data_lo[15:8] : data_lo[7:0];

    // Extend the selected byte/half; a word is the two halves, high at the top.
    always_comb begin
        data = {data_hi, data_lo};
        case (size)
            LSU_SIZE_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            LSU_SIZE_HALF: data = {{16{~is_unsigned & data_lo[15]}}, data_lo};
            default:       data = {data_hi, data_lo};
        endcase
    end

endmodule

// File: rtl/psram_lsu.sv
// Load/store bridge from the core MA stage to the 16-bit psram controller.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for req_valid; latches the request on acceptance
// ISSUE_LO | waiting for !ps_busy, then strobes the low/only half
// WAIT_LO  | waiting for the low half to complete
// ISSUE_HI | waiting for !ps_busy, then strobes the high half (word only)
// WAIT_HI  | waiting for the high half to complete
// DONE     | one-cycle response pulse
module psram_lsu
    import lsu_pkg::*;
#(
    parameter int   TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT,
    parameter logic BANK           = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    output logic                 stall,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_err,
    output logic                 ps_bank_sel,
    output logic [PS_ADDR_W-1:0] ps_addr,
    output logic                 ps_write_en,
    output logic                 ps_read_en,
    output logic [15:0]          ps_data_in,
    output logic                 ps_write_high_byte,
    output logic                 ps_write_low_byte,
    input  logic                 ps_busy,
    input  logic                 ps_read_avail,
    input  logic [15:0]          ps_data_out
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;

    lsu_state_e          state, state_n;
    logic [CW-1:0]       tmo_cnt;
    logic                r_we, r_unsigned;
    logic [22:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [1:0]          r_size;
    lsu_err_e            r_err;
    logic [15:0]         rd_lo, rd_hi;
    logic                accept, misaligned, issue, cap_lo, cap_hi, timeout;
    logic                tmo_tc, store_ready, half_done, is_word;
    logic [PS_ADDR_W-1:0] issue_addr;
    logic [15:0]         issue_data;
    logic                issue_hi_lane, issue_lo_lane;
    logic [31:0]         ext_data;
    logic                unused_addr;

    assign unused_addr = ^req_addr[31:23];
    assign misaligned  = lsu_misaligned(req_size, req_addr[1:0]);
    assign is_word     = r_size[1];
    assign tmo_tc      = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    // The strobe cycle and the one after it are skipped so a controller that
    // raises busy a cycle late is not mistaken for an already finished write.
    assign store_ready = (tmo_cnt >= CW'(2)) && !ps_busy;
    assign half_done   = r_we ? store_ready : ps_read_avail;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    // Next-state decode, per-state control pulses and stall.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        issue   = 1'b0;
        cap_lo  = 1'b0;
        cap_hi  = 1'b0;
        timeout = 1'b0;
        stall   = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_n = misaligned ? ST_DONE : ST_ISSUE_LO;
                end
            end
            ST_ISSUE_LO, ST_ISSUE_HI: begin
                stall = 1'b1;
                if (!ps_busy) begin
                    issue   = 1'b1;
                    state_n = (state == ST_ISSUE_LO) ? ST_WAIT_LO : ST_WAIT_HI;
                end else if (tmo_tc) begin
                    timeout = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_WAIT_LO: begin
                stall = 1'b1;
                if (half_done) begin
                    cap_lo  = !r_we;
                    state_n = is_word ? ST_ISSUE_HI : ST_DONE;
                end else if (tmo_tc) begin
                    timeout = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_WAIT_HI: begin
                stall = 1'b1;
                if (half_done) begin
                    cap_hi  = !r_we;
                    state_n = ST_DONE;
                end else if (tmo_tc) begin
                    timeout = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Timeout counter: cycles spent in the current ISSUE/WAIT state.
    always_ff @(posedge clk) begin
        if (!reset_n)              tmo_cnt <= '0;
        else if (state_n != state) tmo_cnt <= '0;
        else if (state inside {ST_ISSUE_LO, ST_WAIT_LO, ST_ISSUE_HI, ST_WAIT_HI})
                                   tmo_cnt <= tmo_cnt + CW'(1);
        else                       tmo_cnt <= '0;
    end

    // Address, data and lane enables for the half being issued.
    always_comb begin
        issue_addr    = r_addr[22:1];
        issue_data    = r_wdata[15:0];
        issue_hi_lane = 1'b1;
        issue_lo_lane = 1'b1;
        if (state == ST_ISSUE_HI) begin
            issue_addr = r_addr[22:1] + 22'd1;
            issue_data = r_wdata[31:16];
        end else if (r_size == LSU_SIZE_BYTE) begin
            issue_data    = {2{r_wdata[7:0]}};
            issue_hi_lane = r_addr[0];
            issue_lo_lane = !r_addr[0];
        end
    end

    // Request latch, registered psram outputs and read-data capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_we               <= 1'b0;
            r_unsigned         <= 1'b0;
            r_addr             <= '0;
            r_wdata            <= '0;
            r_size             <= '0;
            r_err              <= LSU_ERR_NONE;
            rd_lo              <= '0;
            rd_hi              <= '0;
            ps_addr            <= '0;
            ps_data_in         <= '0;
            ps_write_en        <= 1'b0;
            ps_read_en         <= 1'b0;
            ps_write_high_byte <= 1'b0;
            ps_write_low_byte  <= 1'b0;
        end else begin
            ps_write_en <= 1'b0;
            ps_read_en  <= 1'b0;
            if (accept) begin
                r_we       <= req_we;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr[22:0];
                r_wdata    <= req_wdata;
                r_size     <= req_size;
                r_err      <= misaligned ? LSU_ERR_MISALIGNED : LSU_ERR_NONE;
                rd_lo      <= '0;
                rd_hi      <= '0;
            end
            if (issue) begin
                ps_addr            <= issue_addr;
                ps_data_in         <= issue_data;
                ps_write_high_byte <= issue_hi_lane;
                ps_write_low_byte  <= issue_lo_lane;
                ps_write_en        <= r_we;
                ps_read_en         <= !r_we;
            end
            if (cap_lo)  rd_lo <= ps_data_out;
            if (cap_hi)  rd_hi <= ps_data_out;
            if (timeout) r_err <= LSU_ERR_TIMEOUT;
        end
    end

    lsu_extend u_extend (
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .lane_hi     (r_addr[0]),
        .data_lo     (rd_lo),
        .data_hi     (rd_hi),
        .data        (ext_data)
    );

    assign ps_bank_sel = BANK;
    assign rsp_valid   = (state == ST_DONE);
    assign rsp_err     = rsp_valid ? 2'(r_err) : 2'd0;
    assign rsp_rdata   = (rsp_valid && !r_we && r_err == LSU_ERR_NONE) ? ext_data : 32'd0;

endmodule

// File: tb/tb_psram_lsu.sv
// Bench for psram_lsu: psram controller emulation plus a byte-level memory model.
module tb_psram_lsu;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        stall, rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        ps_bank_sel, ps_write_en, ps_read_en;
    logic [21:0] ps_addr;
    logic [15:0] ps_data_in, ps_data_out;
    logic        ps_write_high_byte, ps_write_low_byte;
    logic        ps_busy, ps_read_avail;

    psram_lsu #(.TIMEOUT_CYCLES(TMO), .BANK(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ps_bank_sel(ps_bank_sel), .ps_addr(ps_addr), .ps_write_en(ps_write_en),
        .ps_read_en(ps_read_en), .ps_data_in(ps_data_in),
        .ps_write_high_byte(ps_write_high_byte), .ps_write_low_byte(ps_write_low_byte),
        .ps_busy(ps_busy), .ps_read_avail(ps_read_avail), .ps_data_out(ps_data_out)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Controller-side storage (16-bit words) and reference memory (bytes).
    logic [15:0] ctl_mem [int];
    logic [7:0]  ref_mem [int];
    int          rd_lat = 1, wr_lat = 0, force_busy = 0, rd_wait = 0, wr_busy = 0;
    bit          drop_reads = 0;
    logic [15:0] rd_data;

    int          st_cyc[$];
    logic [21:0] st_addr[$];
    logic [15:0] st_data[$];
    logic [1:0]  st_lanes[$];
    logic        st_we[$];

    function automatic logic [15:0] ctl_rd(input logic [21:0] a);
        return ctl_mem.exists(int'(a)) ? ctl_mem[int'(a)] : 16'h0;
    endfunction

    function automatic logic [7:0] ref_byte(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h0;
    endfunction

    task automatic preload_word(input int w, input logic [15:0] v);
        ctl_mem[w]       = v;
        ref_mem[2*w]     = v[7:0];
        ref_mem[2*w + 1] = v[15:8];
    endtask

    function automatic bit is_mis(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        int a = int'(addr[22:0]);
        logic [7:0]  b;
        logic [15:0] h;
        if (size == 2'd0) begin
            b = ref_byte(a);
            return uns ? {24'h0, b} : {{24{b[7]}}, b};
        end else if (size == 2'd1) begin
            h = {ref_byte(a + 1), ref_byte(a)};
            return uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return {ref_byte(a + 3), ref_byte(a + 2), ref_byte(a + 1), ref_byte(a)};
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        int a = int'(addr[22:0]);
        int n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
    endtask

    task automatic clear_log();
        st_cyc.delete(); st_addr.delete(); st_data.delete(); st_lanes.delete(); st_we.delete();
    endtask

    // Psram controller emulation, updated just after each rising edge.
    initial begin
        ps_busy = 1'b0; ps_read_avail = 1'b0; ps_data_out = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            ps_read_avail = 1'b0;
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) begin
                    ps_read_avail = 1'b1;
                    ps_data_out   = rd_data;
                end
            end
            if (ps_read_en || ps_write_en) begin
                chk("strobe_exclusive", 32'(ps_read_en & ps_write_en), 32'd0);
                st_cyc.push_back(cyc);
                st_addr.push_back(ps_addr);
                st_data.push_back(ps_data_in);
                st_lanes.push_back({ps_write_high_byte, ps_write_low_byte});
                st_we.push_back(ps_write_en);
            end
            if (ps_write_en) begin
                logic [15:0] w;
                w = ctl_rd(ps_addr);
                if (ps_write_high_byte) w[15:8] = ps_data_in[15:8];
                if (ps_write_low_byte)  w[7:0]  = ps_data_in[7:0];
                ctl_mem[int'(ps_addr)] = w;
                wr_busy = wr_lat;
            end
            if (ps_read_en && !drop_reads) begin
                rd_data = ctl_rd(ps_addr);
                rd_wait = rd_lat;
            end
            ps_busy = (force_busy > 0) || (wr_busy > 0);
            if (force_busy > 0) force_busy--;
            if (wr_busy > 0)    wr_busy--;
        end
    end

    // One core transaction; lat counts cycles from acceptance to the response.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic uns, input int busy_pre,
                             output logic [31:0] rdata, output logic [1:0] err,
                             output int lat, output int acc_cyc);
        bit got = 0;
        rdata = 32'h0; err = 2'd0; lat = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns; force_busy = busy_pre;
        acc_cyc = cyc;
        for (int i = 1; i <= 300 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1; lat = i; rdata = rsp_rdata; err = rsp_err;
                chk("stall_low_in_rsp", 32'(stall), 32'd0);
                req_valid = 1'b0;
            end else begin
                chk("stall_high_while_busy", 32'(stall), 32'd1);
            end
        end
        if (!got) begin
            chk("rsp_arrived", 32'(rsp_valid), 32'd1);
            req_valid = 1'b0;
        end
        @(negedge clk);
        chk("rsp_single_pulse", 32'(rsp_valid), 32'd0);
    endtask

    logic [31:0] rd, exp_rd, a, wd;
    logic [1:0]  er, sz;
    logic        we, un;
    int          lat, acc, nst;
    bit          got;

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_size = 2'd0; req_unsigned = 1'b0;
        for (int w = 0; w < 64; w++) preload_word(w, 16'($urandom));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_strobes", 32'({ps_write_en, ps_read_en}), 32'd0);
        chk("rst_ps_addr", 32'(ps_addr), 32'd0);
        chk("rst_ps_data", 32'(ps_data_in), 32'd0);
        chk("rst_lanes", 32'({ps_write_high_byte, ps_write_low_byte}), 32'd0);
        chk("rst_bank", 32'(ps_bank_sel), 32'd0);

        // Byte loads from the high lane of word 0x80.
        preload_word(32'h80, 16'h80AA);
        rd_lat = 2;
        do_access(1'b0, 32'h0000_0101, 32'h0, 2'd0, 1'b0, 0, rd, er, lat, acc);
        chk("lb_signed_data", rd, 32'hFFFF_FF80);
        chk("lb_signed_err", 32'(er), 32'd0);
        chk("lb_latency", 32'(lat), 32'(3 + 2));
        do_access(1'b0, 32'h0000_0101, 32'h0, 2'd0, 1'b1, 0, rd, er, lat, acc);
        chk("lbu_data", rd, 32'h0000_0080);

        // Word store, then read it back.
        clear_log();
        wr_lat = 2;
        do_access(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, rd, er, lat, acc);
        ref_store(32'h0000_0100, 2'd2, 32'hDEAD_BEEF);
        chk("sw_strobe_count", 32'(st_cyc.size()), 32'd2);
        if (st_cyc.size() >= 2) begin
            chk("sw_lo_addr", 32'(st_addr[0]), 32'h80);
            chk("sw_lo_data", 32'(st_data[0]), 32'hBEEF);
            chk("sw_lo_lanes", 32'(st_lanes[0]), 32'd3);
            chk("sw_lo_we", 32'(st_we[0]), 32'd1);
            chk("sw_hi_addr", 32'(st_addr[1]), 32'h81);
            chk("sw_hi_data", 32'(st_data[1]), 32'hDEAD);
            chk("sw_hi_lanes", 32'(st_lanes[1]), 32'd3);
        end
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata", rd, 32'd0);
        do_access(1'b0, 32'h0000_0100, 32'h0, 2'd2, 1'b0, 0, rd, er, lat, acc);
        chk("lw_readback", rd, 32'hDEAD_BEEF);

        // Misaligned half store.
        clear_log();
        do_access(1'b1, 32'h0000_0003, 32'h0000_1234, 2'd1, 1'b0, 0, rd, er, lat, acc);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_rdata", rd, 32'd0);
        chk("mis_latency", 32'(lat), 32'd1);
        chk("mis_no_strobe", 32'(st_cyc.size()), 32'd0);

        // Word load with the controller busy for 5 cycles at issue.
        preload_word(32'h20, 16'hA5C3);
        preload_word(32'h21, 16'h7E18);
        clear_log();
        rd_lat = 1;
        do_access(1'b0, 32'h0000_0040, 32'h0, 2'd2, 1'b0, 5, rd, er, lat, acc);
        chk("busy_word_data", rd, 32'h7E18_A5C3);
        chk("busy_err", 32'(er), 32'd0);
        chk("busy_strobe_count", 32'(st_cyc.size()), 32'd2);
        if (st_cyc.size() >= 2) begin
            chk("busy_strobe_delay", 32'(st_cyc[0] - acc), 32'd7);
            chk("busy_hi_addr", 32'(st_addr[1]), 32'h21);
        end

        // Controller drops the read: timeout, then recovery.
        drop_reads = 1;
        do_access(1'b0, 32'h0000_0010, 32'h0, 2'd0, 1'b0, 0, rd, er, lat, acc);
        chk("tmo_err", 32'(er), 32'd2);
        chk("tmo_rdata", rd, 32'd0);
        chk("tmo_latency", 32'(lat), 32'(TMO + 2));
        chk("tmo_idle_stall", 32'(stall), 32'd0);
        drop_reads = 0;
        do_access(1'b0, 32'h0000_0010, 32'h0, 2'd1, 1'b0, 0, rd, er, lat, acc);
        chk("tmo_recover_data", rd, ref_load(32'h0000_0010, 2'd1, 1'b0));
        chk("tmo_recover_err", 32'(er), 32'd0);

        // Randomized traffic against the byte-level reference.
        for (int it = 0; it < 80; it++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            un = 1'($urandom_range(0, 1));
            wd = $urandom;
            a  = {9'($urandom_range(0, 511)), 23'($urandom_range(0, 123))};
            rd_lat = $urandom_range(1, 4);
            wr_lat = $urandom_range(0, 3);
            exp_rd = ref_load(a, sz, un);
            nst = st_cyc.size();
            do_access(we, a, wd, sz, un, 0, rd, er, lat, acc);
            if (is_mis(sz, a)) begin
                chk("rnd_mis_err", 32'(er), 32'd1);
                chk("rnd_mis_rdata", rd, 32'd0);
                chk("rnd_mis_latency", 32'(lat), 32'd1);
                chk("rnd_mis_no_strobe", 32'(st_cyc.size()), 32'(nst));
            end else if (we) begin
                ref_store(a, sz, wd);
                chk("rnd_st_err", 32'(er), 32'd0);
                chk("rnd_st_rdata", rd, 32'd0);
            end else begin
                chk("rnd_ld_err", 32'(er), 32'd0);
                chk("rnd_ld_data", rd, exp_rd);
                if (sz != 2'd2) chk("rnd_ld_latency", 32'(lat), 32'(3 + rd_lat));
            end
        end

        // Reset while the high half of a word store is in flight.
        clear_log();
        wr_lat = 3;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0200;
        req_wdata = 32'h1357_9BDF; req_size = 2'd2; req_unsigned = 1'b0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (st_cyc.size() >= 2) got = 1;
        end
        chk("reached_wait_hi", 32'(got), 32'd1);
        reset_n = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_strobes", 32'({ps_write_en, ps_read_en}), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        reset_n = 1'b1;
        nst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) nst++;
        end
        chk("mid_rst_no_rsp", 32'(nst), 32'd0);
        do_access(1'b0, 32'h0000_0040, 32'h0, 2'd2, 1'b0, 0, rd, er, lat, acc);
        chk("post_rst_load", rd, ref_load(32'h0000_0040, 2'd2, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
